// File: rtl/multiplier_pkg.sv
// Shared types for the serial shift-and-add multiplier.
// Holds the FSM state encoding; widths derive from DATA_WIDTH.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_xxbit_serial.sv
// Ripple-carry adder used once per multiplier step.
// Carry ripples through DATA_WIDTH full-adder cells.
module adder_xxbit_serial #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_cry,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry
);

  logic [DATA_WIDTH:0] cry;

  assign cry[0] = i_cry;

  // One full-adder cell per bit, carry chained upward
  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_fa
    logic p;
    assign p = i_num_a[g] ^ i_num_b[g];
    assign o_res[g] = p ^ cry[g];
    assign cry[g+1] = (i_num_a[g] & i_num_b[g])
                    | (p & cry[g]);
  end

  assign o_cry = cry[DATA_WIDTH];

endmodule

// File: rtl/multiplier_xxbit_serial.sv
// Unsigned sequential shift-and-add multiplier.
// One product bit retires per cycle; carry becomes the new MSB.
module multiplier_xxbit_serial
  import multiplier_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_vld,
  output logic                    o_rdy,
  input  logic [DATA_WIDTH-1:0]   i_num_a,
  input  logic [DATA_WIDTH-1:0]   i_num_b,
  output logic                    o_vld,
  input  logic                    i_rdy,
  output logic [2*DATA_WIDTH-1:0] o_res
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    mul_q, mul_d;
  logic [2*W-1:0]  prd_q, prd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [W-1:0]    add_a;
  logic [W-1:0]    add_b;
  logic [W-1:0]    add_s;
  logic            add_c;

  // Upper half accumulates; multiplicand gated by the current LSB
  assign add_a = prd_q[2*W-1:W];
  assign add_b = prd_q[0] ? mul_q : '0;

  adder_xxbit_serial #(
    .DATA_WIDTH (W)
  ) u_add (
    .i_num_a (add_a),
    .i_num_b (add_b),
    .i_cry   (1'b0),
    .o_res   (add_s),
    .o_cry   (add_c)
  );

  // State and datapath registers, cleared on reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      mul_q   <= '0;
      prd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mul_q   <= mul_d;
      prd_q   <= prd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d = state_q;
    mul_d   = mul_q;
    prd_d   = prd_q;
    cnt_d   = cnt_q;
    o_rdy   = 1'b0;
    o_vld   = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_rdy = 1'b1;
        if (i_vld) begin
          mul_d   = i_num_a;
          prd_d   = {{W{1'b0}}, i_num_b};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        prd_d = {add_c, add_s, prd_q[W-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_vld = 1'b1;
        if (i_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_res = prd_q;

endmodule

// File: tb/tb_multiplier_xxbit_serial.sv
// Bench for multiplier_xxbit_serial: latency/product model
// plus directed vectors with literal expectations.
module tb_multiplier_xxbit_serial;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           i_vld;
  logic           o_rdy;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           o_vld;
  logic           i_rdy;
  logic [2*W-1:0] o_res;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  multiplier_xxbit_serial #(
    .DATA_WIDTH (W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_vld   (i_vld),
    .o_rdy   (o_rdy),
    .i_num_a (a),
    .i_num_b (b),
    .o_vld   (o_vld),
    .i_rdy   (i_rdy),
    .o_res   (o_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: busy flag, cycles since accept, exact product
  bit             m_busy;
  int             m_cyc;
  logic [2*W-1:0] m_prod;
  logic [2*W-1:0] m_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cyc  <= 0;
      m_prod <= '0;
      m_last <= '0;
    end else if (!m_busy) begin
      if (i_vld) begin
        m_busy <= 1'b1;
        m_cyc  <= 0;
        m_prod <= (2*W)'(a) * (2*W)'(b);
      end
    end else if (m_cyc < W) begin
      m_cyc <= m_cyc + 1;
    end else if (i_rdy) begin
      m_busy <= 1'b0;
      m_last <= m_prod;
    end
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rdy", 32'(o_rdy), 32'(!m_busy));
      chk("m_vld", 32'(o_vld),
          32'(m_busy && m_cyc == W));
      if (!m_busy)
        chk("m_res_idle", 32'(o_res), 32'(m_last));
      else if (m_cyc == W)
        chk("m_res_done", 32'(o_res), 32'(m_prod));
    end
  end

  task automatic start(input logic [W-1:0] x,
                       input logic [W-1:0] y);
    i_vld = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    i_vld = 1'b0;
  endtask

  task automatic finish(input string nm,
                        input logic [31:0] exp,
                        input int lat,
                        input int hold);
    int n;
    n = 0;
    while (!o_vld && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    chk({nm, "_res"}, 32'(o_res), exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({nm, "_hold_vld"}, 32'(o_vld), 32'd1);
      chk({nm, "_hold_res"}, 32'(o_res), exp);
    end
    i_rdy = 1'b1;
    @(posedge clk);
    #1;
    i_rdy = 1'b0;
    chk({nm, "_rdy_after"}, 32'(o_rdy), 32'd1);
    chk({nm, "_vld_after"}, 32'(o_vld), 32'd0);
    chk({nm, "_res_kept"}, 32'(o_res), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_vld = 1'b0;
    i_rdy = 1'b0;
    a = '0;
    b = '0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_rdy", 32'(o_rdy), 32'd1);
    chk("rst_vld", 32'(o_vld), 32'd0);
    chk("rst_res", 32'(o_res), 32'd0);

    i_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rdy = 1'b0;
    chk("rdy_idle_noeffect", 32'(o_rdy), 32'd1);

    start(8'd13, 8'd11);
    finish("basic", 32'd143, W, 0);

    start(8'd255, 8'd255);
    finish("max", 32'd65025, W, 0);

    start(8'd0, 8'd200);
    finish("zero_a", 32'd0, W, 0);

    start(8'd200, 8'd0);
    finish("zero_b", 32'd0, W, 0);

    start(8'd7, 8'd9);
    finish("bp", 32'd63, W, 5);

    start(8'd20, 8'd10);
    @(posedge clk);
    #1;
    i_vld = 1'b1;
    a = 8'd3;
    b = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    i_vld = 1'b0;
    finish("ignore", 32'd200, W - 4, 0);

    start(8'd100, 8'd100);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_vld", 32'(o_vld), 32'd0);
    chk("rstmid_res", 32'(o_res), 32'd0);
    chk("rstmid_rdy", 32'(o_rdy), 32'd1);
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start(8'd5, 8'd6);
    finish("after_rst", 32'd30, W, 0);

    start(8'd1, 8'd128);
    finish("pow2", 32'd128, W, 1);

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
